// File: rtl/mem_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_request_arbiter
// Description : Arbitrates NCH requestors onto one single-port synchronous RAM
//               with configurable access latency; flags misaligned accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_request_arbiter #(
    parameter int NCH     = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int RAW     = 12,
    parameter int LATENCY = 1,
    parameter int RR_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    wen,
    input  logic [NCH*AW-1:0] addr,
    input  logic [NCH*DW-1:0] wdata,
    output logic [DW-1:0]     rdata,
    output logic [NCH-1:0]    ready,
    output logic              err,
    output logic              busy,
    output logic [RAW-1:0]    ram_addr,
    output logic [DW-1:0]     ram_wdata,
    output logic              ram_wen,
    output logic              ram_ren,
    input  logic [DW-1:0]     ram_rdata
);

    localparam int c_GW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int c_CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;

    localparam logic [c_CW-1:0] c_CNT_LOAD = c_CW'(LATENCY - 1);

    logic [1:0]      r_state_q,     w_state_d;
    logic [c_GW-1:0] r_gnt_q,       w_gnt_d;
    logic [c_GW-1:0] r_ptr_q,       w_ptr_d;
    logic [c_CW-1:0] r_cnt_q,       w_cnt_d;
    logic [DW-1:0]   r_rdata_q,     w_rdata_d;
    logic [NCH-1:0]  r_ready_q,     w_ready_d;
    logic            r_err_q,       w_err_d;
    logic            r_busy_q,      w_busy_d;
    logic [RAW-1:0]  r_ram_addr_q,  w_ram_addr_d;
    logic [DW-1:0]   r_ram_wdata_q, w_ram_wdata_d;
    logic            r_ram_wen_q,   w_ram_wen_d;
    logic            r_ram_ren_q,   w_ram_ren_d;

    logic [c_GW-1:0] w_pick;
    logic            w_pick_wen;
    logic [AW-1:0]   w_pick_addr;
    logic [DW-1:0]   w_pick_wdata;
    int              w_dist;
    int              w_best;
    logic            w_unused;

    // Winner is the requestor at the smallest distance: from the RR pointer in
    // round-robin mode, from the top index in fixed-priority mode.
    always_comb begin
        w_pick = '0;
        w_best = NCH;
        w_dist = 0;
        for (int i = 0; i < NCH; i++) begin
            if (RR_MODE != 0) begin
                w_dist = (i >= int'(r_ptr_q)) ? (i - int'(r_ptr_q))
                                              : (i + NCH - int'(r_ptr_q));
            end else begin
                w_dist = NCH - 1 - i;
            end
            if (req[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_pick = c_GW'(i);
            end
        end
        w_pick_wen   = 1'b0;
        w_pick_addr  = '0;
        w_pick_wdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_pick == c_GW'(i)) begin
                w_pick_wen   = wen[i];
                w_pick_addr  = addr[i*AW +: AW];
                w_pick_wdata = wdata[i*DW +: DW];
            end
        end
    end

    // Address bits above the RAM window wrap around by design.
    assign w_unused = ^{w_pick_addr[AW-1:RAW+2]};

    always_comb begin
        w_state_d     = r_state_q;
        w_gnt_d       = r_gnt_q;
        w_ptr_d       = r_ptr_q;
        w_cnt_d       = r_cnt_q;
        w_rdata_d     = '0;
        w_ready_d     = '0;
        w_err_d       = 1'b0;
        w_ram_addr_d  = r_ram_addr_q;
        w_ram_wdata_d = r_ram_wdata_q;
        w_ram_wen_d   = r_ram_wen_q;
        w_ram_ren_d   = r_ram_ren_q;
        case (r_state_q)
            c_ST_IDLE: begin
                if (|req) begin
                    w_gnt_d = w_pick;
                    w_ptr_d = (w_pick == c_GW'(NCH - 1)) ? '0 : (w_pick + 1'b1);
                    w_cnt_d = c_CNT_LOAD;
                    if (w_pick_addr[1:0] == 2'b00) begin
                        w_state_d     = c_ST_ACCESS;
                        w_ram_addr_d  = w_pick_addr[RAW+1:2];
                        w_ram_wdata_d = w_pick_wdata;
                        w_ram_wen_d   = w_pick_wen;
                        w_ram_ren_d   = ~w_pick_wen;
                    end else begin
                        w_state_d = c_ST_DONE;
                        w_ready_d = NCH'(1) << w_pick;
                        w_err_d   = 1'b1;
                    end
                end
            end
            c_ST_ACCESS: begin
                if (r_cnt_q == '0) begin
                    w_state_d   = c_ST_DONE;
                    w_ready_d   = NCH'(1) << r_gnt_q;
                    w_rdata_d   = r_ram_wen_q ? '0 : ram_rdata;
                    w_ram_wen_d = 1'b0;
                    w_ram_ren_d = 1'b0;
                end else begin
                    w_cnt_d = r_cnt_q - 1'b1;
                end
            end
            default: begin
                w_state_d = c_ST_IDLE;
            end
        endcase
        w_busy_d = (w_state_d != c_ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= c_ST_IDLE;
            r_gnt_q       <= '0;
            r_ptr_q       <= '0;
            r_cnt_q       <= '0;
            r_rdata_q     <= '0;
            r_ready_q     <= '0;
            r_err_q       <= 1'b0;
            r_busy_q      <= 1'b0;
            r_ram_addr_q  <= '0;
            r_ram_wdata_q <= '0;
            r_ram_wen_q   <= 1'b0;
            r_ram_ren_q   <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_gnt_q       <= w_gnt_d;
            r_ptr_q       <= w_ptr_d;
            r_cnt_q       <= w_cnt_d;
            r_rdata_q     <= w_rdata_d;
            r_ready_q     <= w_ready_d;
            r_err_q       <= w_err_d;
            r_busy_q      <= w_busy_d;
            r_ram_addr_q  <= w_ram_addr_d;
            r_ram_wdata_q <= w_ram_wdata_d;
            r_ram_wen_q   <= w_ram_wen_d;
            r_ram_ren_q   <= w_ram_ren_d;
        end
    end

    assign rdata     = r_rdata_q;
    assign ready     = r_ready_q;
    assign err       = r_err_q;
    assign busy      = r_busy_q;
    assign ram_addr  = r_ram_addr_q;
    assign ram_wdata = r_ram_wdata_q;
    assign ram_wen   = r_ram_wen_q;
    assign ram_ren   = r_ram_ren_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_request_arbiter
// Description : Directed table-driven bench for mem_request_arbiter across
//               fixed-priority, round-robin and multi-cycle latency builds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_request_arbiter;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  wen;
        logic [31:0] a0, a1, d0, d1;
        logic [1:0]  exp_ready;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_cyc;
        int          exp_strb;
        logic [11:0] exp_raddr;
        logic        exp_wen;
        logic [31:0] exp_wdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_c = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    // Instance A: NCH=2, LATENCY=1, fixed priority
    logic [1:0]  req_a = '0, wen_a = '0, ready_a;
    logic [63:0] addr_a = '0, wdata_a = '0;
    logic [31:0] rdata_a, ram_wdata_a, ram_rdata_a;
    logic [11:0] ram_addr_a;
    logic        err_a, busy_a, ram_wen_a, ram_ren_a;
    logic [31:0] mem_a [16];

    mem_request_arbiter #(.NCH(2), .LATENCY(1), .RR_MODE(0)) u_dut_a (
        .clk(clk), .rst(rst), .req(req_a), .wen(wen_a), .addr(addr_a), .wdata(wdata_a),
        .rdata(rdata_a), .ready(ready_a), .err(err_a), .busy(busy_a),
        .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a), .ram_wen(ram_wen_a),
        .ram_ren(ram_ren_a), .ram_rdata(ram_rdata_a));

    assign ram_rdata_a = mem_a[ram_addr_a[3:0]];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem_a[i] <= (i == 2) ? 32'hDEADBEEF : 32'hA000_0000 + i;
        end else if (ram_wen_a) begin
            mem_a[ram_addr_a[3:0]] <= ram_wdata_a;
        end
    end

    // Instance B: NCH=3, LATENCY=1, round robin
    logic [2:0]  req_b = '0, wen_b = '0, ready_b;
    logic [95:0] addr_b, wdata_b;
    logic [31:0] rdata_b, ram_wdata_b, ram_rdata_b;
    logic [11:0] ram_addr_b;
    logic        err_b, busy_b, ram_wen_b, ram_ren_b;

    assign addr_b  = {32'h8, 32'h4, 32'h0};
    assign wdata_b = '0;
    assign ram_rdata_b = 32'hB000_0000 + {20'h0, ram_addr_b};

    mem_request_arbiter #(.NCH(3), .LATENCY(1), .RR_MODE(1)) u_dut_b (
        .clk(clk), .rst(rst), .req(req_b), .wen(wen_b), .addr(addr_b), .wdata(wdata_b),
        .rdata(rdata_b), .ready(ready_b), .err(err_b), .busy(busy_b),
        .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b), .ram_wen(ram_wen_b),
        .ram_ren(ram_ren_b), .ram_rdata(ram_rdata_b));

    // Instance C: NCH=2, LATENCY=3, fixed priority, own reset
    logic [1:0]  req_c = '0, wen_c = '0, ready_c;
    logic [63:0] addr_c = '0, wdata_c = '0;
    logic [31:0] rdata_c, ram_wdata_c, ram_rdata_c;
    logic [11:0] ram_addr_c;
    logic        err_c, busy_c, ram_wen_c, ram_ren_c;
    logic [31:0] mem_c [16];

    mem_request_arbiter #(.NCH(2), .LATENCY(3), .RR_MODE(0)) u_dut_c (
        .clk(clk), .rst(rst_c), .req(req_c), .wen(wen_c), .addr(addr_c), .wdata(wdata_c),
        .rdata(rdata_c), .ready(ready_c), .err(err_c), .busy(busy_c),
        .ram_addr(ram_addr_c), .ram_wdata(ram_wdata_c), .ram_wen(ram_wen_c),
        .ram_ren(ram_ren_c), .ram_rdata(ram_rdata_c));

    assign ram_rdata_c = mem_c[ram_addr_c[3:0]];
    always @(posedge clk) begin
        if (rst_c) begin
            for (int i = 0; i < 16; i++) mem_c[i] <= 32'hC000_0000 + i;
        end else if (ram_wen_c) begin
            mem_c[ram_addr_c[3:0]] <= ram_wdata_c;
        end
    end

    // Muxed view of instance A or C for the shared transaction task
    logic        sel_c = 1'b0;
    logic [1:0]  m_ready;
    logic [31:0] m_rdata, m_wdata;
    logic [11:0] m_raddr;
    logic        m_err, m_busy, m_wen, m_ren;
    assign m_ready = sel_c ? ready_c     : ready_a;
    assign m_rdata = sel_c ? rdata_c     : rdata_a;
    assign m_wdata = sel_c ? ram_wdata_c : ram_wdata_a;
    assign m_raddr = sel_c ? ram_addr_c  : ram_addr_a;
    assign m_err   = sel_c ? err_c       : err_a;
    assign m_busy  = sel_c ? busy_c      : busy_a;
    assign m_wen   = sel_c ? ram_wen_c   : ram_wen_a;
    assign m_ren   = sel_c ? ram_ren_c   : ram_ren_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] rq, input logic [1:0] we,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        if (sel_c) begin
            req_c = rq; wen_c = we; addr_c = {a1, a0}; wdata_c = {d1, d0};
        end else begin
            req_a = rq; wen_a = we; addr_a = {a1, a0}; wdata_a = {d1, d0};
        end
    endtask

    task automatic txn(input logic sc, input vec_t v, input string tag);
        int cyc, strb, bsy;
        logic [11:0] sa;
        logic sw;
        logic [31:0] sd;
        sel_c = sc;
        @(negedge clk);
        drive(v.req, v.wen, v.a0, v.a1, v.d0, v.d1);
        cyc = 0; strb = 0; bsy = 0; sa = '0; sw = 1'b0; sd = '0;
        do begin
            @(negedge clk);
            cyc++;
            if (m_busy) bsy++;
            if (m_ren || m_wen) begin
                strb++; sa = m_raddr; sw = m_wen; sd = m_wdata;
            end
        end while (m_ready == 2'b00 && cyc < 20);
        chk({tag, " latency"}, 32'(cyc), 32'(v.exp_cyc));
        chk({tag, " ready"}, 32'(m_ready), 32'(v.exp_ready));
        chk({tag, " rdata"}, m_rdata, v.exp_rdata);
        chk({tag, " err"}, 32'(m_err), 32'(v.exp_err));
        chk({tag, " strobes"}, 32'(strb), 32'(v.exp_strb));
        chk({tag, " busy cycles"}, 32'(bsy), 32'(v.exp_cyc));
        if (v.exp_strb > 0) begin
            chk({tag, " ram_addr"}, 32'(sa), 32'(v.exp_raddr));
            chk({tag, " ram_wen"}, 32'(sw), 32'(v.exp_wen));
            if (v.exp_wen) chk({tag, " ram_wdata"}, sd, v.exp_wdata);
        end
        drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk({tag, " back to idle"}, 32'({m_ready, m_busy, m_wen, m_ren}), 32'h0);
    endtask

    vec_t vecs [9];
    vec_t vc;
    int   rr_exp [4] = '{0, 1, 2, 0};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // req, wen, a0, a1, d0, d1, ready, rdata, err, cyc, strb, raddr, wen, wdata
        vecs[0] = '{2'b01, 2'b00, 32'h8,     32'h0,  32'h0, 32'h0,    2'b01, 32'hDEADBEEF, 1'b0, 2, 1, 12'h002, 1'b0, 32'h0};
        vecs[1] = '{2'b11, 2'b10, 32'h20,    32'h10, 32'h0, 32'h1234, 2'b10, 32'h0,        1'b0, 2, 1, 12'h004, 1'b1, 32'h1234};
        vecs[2] = '{2'b10, 2'b00, 32'h0,     32'h10, 32'h0, 32'h0,    2'b10, 32'h1234,     1'b0, 2, 1, 12'h004, 1'b0, 32'h0};
        vecs[3] = '{2'b10, 2'b00, 32'h0,     32'h6,  32'h0, 32'h0,    2'b10, 32'h0,        1'b1, 1, 0, 12'h000, 1'b0, 32'h0};
        vecs[4] = '{2'b01, 2'b00, 32'h1000C, 32'h0,  32'h0, 32'h0,    2'b01, 32'hA0000003, 1'b0, 2, 1, 12'h003, 1'b0, 32'h0};
        vecs[5] = '{2'b01, 2'b01, 32'h3,     32'h0,  32'hFFFF, 32'h0, 2'b01, 32'h0,        1'b1, 1, 0, 12'h000, 1'b0, 32'h0};
        vecs[6] = '{2'b11, 2'b00, 32'h8,     32'h2,  32'h0, 32'h0,    2'b10, 32'h0,        1'b1, 1, 0, 12'h000, 1'b0, 32'h0};
        vecs[7] = '{2'b01, 2'b01, 32'hFFC,   32'h0,  32'hCAFEF00D, 32'h0, 2'b01, 32'h0,    1'b0, 2, 1, 12'h3FF, 1'b1, 32'hCAFEF00D};
        vecs[8] = '{2'b01, 2'b00, 32'hFFC,   32'h0,  32'h0, 32'h0,    2'b01, 32'hCAFEF00D, 1'b0, 2, 1, 12'h3FF, 1'b0, 32'h0};
        vc      = '{2'b01, 2'b00, 32'h14,    32'h0,  32'h0, 32'h0,    2'b01, 32'hC0000005, 1'b0, 4, 3, 12'h005, 1'b0, 32'h0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        rst_c = 1'b0;
        @(negedge clk);
        chk("reset A ctl", 32'({ready_a, err_a, busy_a, ram_wen_a, ram_ren_a, ram_addr_a}), 32'h0);
        chk("reset A rdata", rdata_a, 32'h0);
        chk("reset A ram_wdata", ram_wdata_a, 32'h0);
        chk("reset B ctl", 32'({ready_b, err_b, busy_b, ram_wen_b, ram_ren_b}), 32'h0);
        chk("reset C ctl", 32'({ready_c, err_c, busy_c, ram_wen_c, ram_ren_c, ram_addr_c}), 32'h0);

        for (int i = 0; i < 9; i++) txn(1'b0, vecs[i], $sformatf("vecA%0d", i));

        // Fixed priority: ch1 wins, ch0 keeps requesting and follows after the IDLE gap
        begin
            int w;
            sel_c = 1'b0;
            @(negedge clk);
            drive(2'b11, 2'b10, 32'h8, 32'h14, 32'h0, 32'h5678);
            w = 0;
            do begin @(negedge clk); w++; end while (ready_a == 2'b00 && w < 20);
            chk("prio first ready", 32'(ready_a), 32'h2);
            req_a = 2'b01;
            w = 0;
            do begin
                @(negedge clk); w++;
                if (w == 1) chk("prio idle gap busy", 32'(busy_a), 32'h0);
            end while (ready_a == 2'b00 && w < 20);
            chk("prio second gap", 32'(w), 32'd3);
            chk("prio second ready", 32'(ready_a), 32'h1);
            chk("prio second rdata", rdata_a, 32'hDEADBEEF);
            req_a = 2'b00;
            @(negedge clk);
        end

        // Round robin with all three requests held
        @(negedge clk);
        req_b = 3'b111;
        for (int k = 0; k < 4; k++) begin
            int w;
            w = 0;
            do begin
                @(negedge clk); w++;
                if ($countones(ready_b) > 1) chk("rr onehot", 32'(ready_b), 32'h0);
            end while (ready_b == 3'b000 && w < 20);
            chk($sformatf("rr grant %0d", k), 32'(ready_b), 32'(3'b001 << rr_exp[k]));
            chk($sformatf("rr rdata %0d", k), rdata_b, 32'hB000_0000 + 32'(rr_exp[k]));
            chk($sformatf("rr gap %0d", k), 32'(w), (k == 0) ? 32'd2 : 32'd3);
            if (k == 3) req_b = 3'b000;
        end

        // Latency 3 read
        txn(1'b1, vc, "lat3");

        // Reset in the second ACCESS cycle of a latency-3 write
        begin
            int rdy;
            sel_c = 1'b1;
            @(negedge clk);
            drive(2'b10, 2'b10, 32'h0, 32'h18, 32'h0, 32'h55AA);
            @(negedge clk);
            chk("rstmid wen c1", 32'(ram_wen_c), 32'h1);
            @(negedge clk);
            chk("rstmid wen c2", 32'(ram_wen_c), 32'h1);
            rst_c = 1'b1;
            @(negedge clk);
            chk("rstmid forced", 32'({ram_wen_c, ram_ren_c, busy_c, ready_c, err_c}), 32'h0);
            rst_c = 1'b0;
            drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
            rdy = 0;
            repeat (5) begin
                @(negedge clk);
                if (ready_c != 2'b00) rdy++;
            end
            chk("rstmid no ready", 32'(rdy), 32'h0);
        end
        txn(1'b1, vc, "after rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
